send_n_bytes: RTL

SEND_N_BYTES -- requirements
Module: send_n_bytes

---
 rtl/send_n_bytes.sv | 122 ++++++++++++
 1 files changed

// File: rtl/send_n_bytes.sv
// UART transmitter that sends BYTE_NUM bytes per request, most significant byte first.
// Each frame is start, 8 data bits LSB first, parity, stop; consecutive frames have no gap.
module send_n_bytes #(
  parameter int unsigned CLK_FREQ  = 50,
  parameter int unsigned BAUD_RATE = 9600,
  parameter bit          CHECK_SEL = 1'b1,
  parameter int unsigned BYTE_NUM  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_start_i,
  input  logic [8*BYTE_NUM-1:0] nbytes_data_i,
  output logic                  uart_txd_o,
  output logic                  tx_busy_o,
  output logic                  tx_nbytes_done_o
);

  localparam int unsigned BPS_CNT = CLK_FREQ * 1000000 / BAUD_RATE;
  localparam int unsigned CNT_W   = $clog2(BPS_CNT + 1);
  localparam int unsigned DW      = 8 * BYTE_NUM;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BPS_CNT - 1);
  localparam logic [3:0]       BYTE_LAST = 4'(BYTE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       byte_q, byte_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic             txd_d, busy_d, done_d;
  logic [7:0]       cur_byte;

  // State, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      bit_q            <= '0;
      byte_q           <= '0;
      shift_q          <= '0;
      uart_txd_o       <= 1'b1;
      tx_busy_o        <= 1'b0;
      tx_nbytes_done_o <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bit_q            <= bit_d;
      byte_q           <= byte_d;
      shift_q          <= shift_d;
      uart_txd_o       <= txd_d;
      tx_busy_o        <= busy_d;
      tx_nbytes_done_o <= done_d;
    end
  end

  // Next state; the line value is derived from the next state so txd has one cycle of latency
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    txd_d    = 1'b1;
    cur_byte = '0;

    if (state_q == IDLE) begin
      if (tx_start_i) begin
        shift_d = nbytes_data_i;
        byte_d  = '0;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = START;
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      case (state_q)
        START:  state_d = DATA;
        DATA: begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        PARITY: state_d = STOP;
        STOP: begin
          if (byte_q == BYTE_LAST) begin
            byte_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 4'd1;
            shift_d = shift_q << 8;
            state_d = START;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    cur_byte = shift_d[DW-1 -: 8];
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cur_byte[bit_d];
      PARITY:  txd_d = CHECK_SEL ? ~^cur_byte : ^cur_byte;
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule
